// File: rtl/aes_cbc_chain_ctrl.sv
// aes_cbc_chain_ctrl: CBC chaining wrapper around an AES core.
// Accepts one 128-bit block at a time. On encrypt it XORs the block with the
// chaining value before sending it to the core. On decrypt it XORs the core
// result with the chaining value. It also keeps a processed-block counter.
// Optional feature: `define AES_CBC_CHAIN_CTRL_ECB_EN adds the ecb_i port.
// When the latched ecb_i is 1, the block bypasses chaining entirely.
//
// Handshakes: every interface transfers when valid and ready (or ack) are
// both high on a rising clock edge. Once raised, a valid stays high and its
// data/op stay stable until that transfer. res_ack_o is the exception: it is
// combinational and mirrors res_valid_i while the block waits in WAIT.
module aes_cbc_chain_ctrl #(
    parameter int unsigned CntWidth = 16,
    parameter logic [1:0]  OpFwd    = 2'b01,
    parameter logic [1:0]  OpInv    = 2'b10
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                iv_we_i,
    input  logic [127:0]        iv_i,
    input  logic                clear_i,
    input  logic                dec_i,
`ifdef AES_CBC_CHAIN_CTRL_ECB_EN
    input  logic                ecb_i,
`endif
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [127:0]        in_data_i,
    output logic                crypt_valid_o,
    input  logic                crypt_ack_i,
    output logic [127:0]        crypt_data_o,
    output logic [1:0]          crypt_op_o,
    input  logic                res_valid_i,
    output logic                res_ack_o,
    input  logic [127:0]        res_data_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [127:0]        out_data_o,
    output logic                busy_o,
    output logic [CntWidth-1:0] blk_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [127:0]        chain_q, chain_d;
    logic [127:0]        held_q, held_d;
    logic [127:0]        crypt_data_q, crypt_data_d;
    logic [127:0]        out_data_q, out_data_d;
    logic [1:0]          crypt_op_q, crypt_op_d;
    logic                dec_q, dec_d;
    logic                ecb_q, ecb_d;
    logic                in_ready_q, in_ready_d;
    logic                crypt_valid_q, crypt_valid_d;
    logic                out_valid_q, out_valid_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [127:0]        chain_upd;
    logic                ecb_in;

`ifdef AES_CBC_CHAIN_CTRL_ECB_EN
    assign ecb_in = ecb_i;
`else
    assign ecb_in = 1'b0;
`endif

    // Next-state logic: chaining register updates, block capture, core and output sequencing
    always_comb begin
        state_d       = state_q;
        chain_d       = chain_q;
        held_d        = held_q;
        crypt_data_d  = crypt_data_q;
        out_data_d    = out_data_q;
        crypt_op_d    = crypt_op_q;
        dec_d         = dec_q;
        ecb_d         = ecb_q;
        cnt_d         = cnt_q;
        chain_upd     = chain_q;
        unique case (state_q)
            ST_IDLE: begin
                // A block accepted in the same cycle sees the IV/clear update
                if (clear_i) begin
                    chain_upd = '0;
                    cnt_d     = '0;
                end else if (iv_we_i) begin
                    chain_upd = iv_i;
                end
                chain_d = chain_upd;
                if (in_valid_i && in_ready_q) begin
                    dec_d        = dec_i;
                    ecb_d        = ecb_in;
                    held_d       = in_data_i;
                    crypt_data_d = (dec_i || ecb_in) ? in_data_i : (in_data_i ^ chain_upd);
                    crypt_op_d   = dec_i ? OpInv : OpFwd;
                    state_d      = ST_REQ;
                end
            end
            ST_REQ: begin
                if (crypt_ack_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (res_valid_i) begin
                    if (ecb_q) begin
                        out_data_d = res_data_i;
                    end else if (dec_q) begin
                        out_data_d = res_data_i ^ chain_q;
                        chain_d    = held_q;
                    end else begin
                        out_data_d = res_data_i;
                        chain_d    = res_data_i;
                    end
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_ready_i) begin
                    cnt_d   = cnt_q + CntWidth'(1);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d    = (state_d == ST_IDLE);
        crypt_valid_d = (state_d == ST_REQ);
        out_valid_d   = (state_d == ST_OUT);
    end

    // State and registered outputs; reset discards any in-flight block
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            chain_q       <= '0;
            held_q        <= '0;
            crypt_data_q  <= '0;
            out_data_q    <= '0;
            crypt_op_q    <= OpFwd;
            dec_q         <= 1'b0;
            ecb_q         <= 1'b0;
            in_ready_q    <= 1'b1;
            crypt_valid_q <= 1'b0;
            out_valid_q   <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            chain_q       <= chain_d;
            held_q        <= held_d;
            crypt_data_q  <= crypt_data_d;
            out_data_q    <= out_data_d;
            crypt_op_q    <= crypt_op_d;
            dec_q         <= dec_d;
            ecb_q         <= ecb_d;
            in_ready_q    <= in_ready_d;
            crypt_valid_q <= crypt_valid_d;
            out_valid_q   <= out_valid_d;
            cnt_q         <= cnt_d;
        end
    end

    assign in_ready_o    = in_ready_q;
    assign crypt_valid_o = crypt_valid_q;
    assign crypt_data_o  = crypt_data_q;
    assign crypt_op_o    = crypt_op_q;
    assign res_ack_o     = (state_q == ST_WAIT) && res_valid_i;
    assign out_valid_o   = out_valid_q;
    assign out_data_o    = out_data_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign blk_cnt_o     = cnt_q;

endmodule

// File: tb/tb_aes_cbc_chain_ctrl.sv
// tb_aes_cbc_chain_ctrl: bench for aes_cbc_chain_ctrl with an identity AES core stub.
// The stub's ack/result latency and the output back-pressure are programmable.
// Expected core requests and output blocks come from a plain CBC model.
module tb_aes_cbc_chain_ctrl;
    localparam int CW = 2;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          iv_we_i = 1'b0;
    logic [127:0]  iv_i = '0;
    logic          clear_i = 1'b0;
    logic          dec_i = 1'b0;
    logic          ecb_i = 1'b0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [127:0]  in_data_i = '0;
    logic          crypt_valid_o;
    logic          crypt_ack_i;
    logic [127:0]  crypt_data_o;
    logic [1:0]    crypt_op_o;
    logic          res_valid_i;
    logic          res_ack_o;
    logic [127:0]  res_data_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [127:0]  out_data_o;
    logic          busy_o;
    logic [CW-1:0] blk_cnt_o;

    aes_cbc_chain_ctrl #(.CntWidth(CW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .iv_we_i(iv_we_i), .iv_i(iv_i),
        .clear_i(clear_i), .dec_i(dec_i),
`ifdef AES_CBC_CHAIN_CTRL_ECB_EN
        .ecb_i(ecb_i),
`endif
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .crypt_valid_o(crypt_valid_o), .crypt_ack_i(crypt_ack_i),
        .crypt_data_o(crypt_data_o), .crypt_op_o(crypt_op_o),
        .res_valid_i(res_valid_i), .res_ack_o(res_ack_o), .res_data_i(res_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .busy_o(busy_o), .blk_cnt_o(blk_cnt_o)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk_i = ~clk_i;
    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad = 0;
    logic [127:0]  exp_crypt_q[$];
    logic [1:0]    exp_op_q[$];
    logic [127:0]  exp_out_q[$];
    logic [127:0]  m_chain = '0;
    logic [CW-1:0] exp_cnt = '0;
    logic [CW-1:0] pend_cnt = '0;
    bit            cnt_chk = 0;
    bit            lat_arm = 0;
    bit            lat_en = 0;
    int            acc_cyc = 0;

    // stub knobs and state
    int ack_min = 0, ack_max = 0, res_min = 0, res_max = 0, rdy_min = 0, rdy_max = 0;
    bit ack_armed = 0, res_pend = 0, rdy_armed = 0;
    int ack_cnt = 0, res_cnt = 0, rdy_cnt = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic set_waits(input int a0, input int a1, input int r0, input int r1,
                             input int o0, input int o1);
        ack_min = a0; ack_max = a1; res_min = r0; res_max = r1; rdy_min = o0; rdy_max = o1;
    endtask

    // ---------------- core stub and output sink ----------------
    initial begin
        crypt_ack_i = 1'b0; res_valid_i = 1'b0; res_data_i = '0; out_ready_i = 1'b0;
        forever begin
            @(negedge clk_i);
            crypt_ack_i = 1'b0; res_valid_i = 1'b0; out_ready_i = 1'b0;
            if (!rst_ni) begin
                ack_armed = 0; res_pend = 0; rdy_armed = 0;
            end else begin
                if (crypt_valid_o) begin
                    if (!ack_armed) begin
                        ack_armed = 1; ack_cnt = $urandom_range(ack_max, ack_min);
                    end
                    if (ack_cnt == 0) begin
                        crypt_ack_i = 1'b1; ack_armed = 0;
                        res_pend = 1; res_cnt = $urandom_range(res_max, res_min);
                        res_data_i = crypt_data_o;
                    end else ack_cnt--;
                end else if (res_pend) begin
                    if (res_cnt == 0) begin
                        res_valid_i = 1'b1; res_pend = 0;
                    end else res_cnt--;
                end
                if (out_valid_o) begin
                    if (!rdy_armed) begin
                        rdy_armed = 1; rdy_cnt = $urandom_range(rdy_max, rdy_min);
                    end
                    if (rdy_cnt == 0) begin
                        out_ready_i = 1'b1; rdy_armed = 0;
                    end else rdy_cnt--;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk_i);
            #1;
            if (!rst_ni) continue;
            if (cnt_chk) begin
                cnt_chk = 0;
                chk("blk_cnt", 128'(blk_cnt_o), 128'(pend_cnt));
            end
            if (crypt_valid_o) begin
                chk("in_ready_in_req", 128'(in_ready_o), 128'(0));
                if (exp_crypt_q.size() == 0) begin
                    chk("crypt_unexpected", 128'(1), 128'(0));
                end else begin
                    chk("crypt_data", crypt_data_o, exp_crypt_q[0]);
                    chk("crypt_op", 128'(crypt_op_o), 128'(exp_op_q[0]));
                    if (crypt_ack_i) begin
                        void'(exp_crypt_q.pop_front());
                        void'(exp_op_q.pop_front());
                    end
                end
            end
            if (res_valid_i) chk("res_ack", 128'(res_ack_o), 128'(1));
            if (out_valid_o) begin
                chk("in_ready_in_out", 128'(in_ready_o), 128'(0));
                if (lat_arm) begin
                    lat_arm = 0;
                    if (lat_en) chk("latency", 128'(cyc - acc_cyc), 128'(3));
                end
                if (exp_out_q.size() == 0) begin
                    chk("out_unexpected", 128'(1), 128'(0));
                end else begin
                    chk("out_data", out_data_o, exp_out_q[0]);
                    if (out_ready_i) begin
                        void'(exp_out_q.pop_front());
                        exp_cnt  = exp_cnt + 1'b1;
                        pend_cnt = exp_cnt;
                        cnt_chk  = 1;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle(input string name, output bit ok);
        int n = 0;
        @(negedge clk_i);
        while (!in_ready_o && n < 400) begin
            @(negedge clk_i);
            n++;
        end
        ok = in_ready_o;
        if (!ok) chk({name, "_timeout"}, 128'(0), 128'(1));
    endtask

    task automatic load_ctrl(input bit do_iv, input logic [127:0] iv, input bit do_clr);
        bit ok;
        wait_idle("load", ok);
        if (!ok) return;
        if (do_clr) begin
            m_chain = '0; exp_cnt = '0;
        end else if (do_iv) m_chain = iv;
        iv_we_i = do_iv; iv_i = iv; clear_i = do_clr;
        @(negedge clk_i);
        iv_we_i = 1'b0; clear_i = 1'b0;
    endtask

    // Issues one block; the model computes plain CBC with an identity cipher
    task automatic send_block(input logic [127:0] d, input bit dec, input bit ecb,
                              input bit do_iv, input logic [127:0] iv, input bit do_clr);
        bit ok;
        logic [127:0] cd, od;
        wait_idle("send", ok);
        if (!ok) return;
        if (do_clr) begin
            m_chain = '0; exp_cnt = '0;
        end else if (do_iv) m_chain = iv;
        if (dec) begin
            cd = d;
            od = ecb ? d : (d ^ m_chain);
            if (!ecb) m_chain = d;
        end else begin
            cd = ecb ? d : (d ^ m_chain);
            od = cd;
            if (!ecb) m_chain = cd;
        end
        exp_crypt_q.push_back(cd);
        exp_op_q.push_back(dec ? 2'b10 : 2'b01);
        exp_out_q.push_back(od);
        in_valid_i = 1'b1; in_data_i = d; dec_i = dec; ecb_i = ecb;
        iv_we_i = do_iv; iv_i = iv; clear_i = do_clr;
        acc_cyc = cyc; lat_arm = 1;
        @(negedge clk_i);
        in_valid_i = 1'b0; iv_we_i = 1'b0; clear_i = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 128'(in_ready_o), 128'(1));
        chk({tag, "_crypt_valid"}, 128'(crypt_valid_o), 128'(0));
        chk({tag, "_res_ack"}, 128'(res_ack_o), 128'(0));
        chk({tag, "_out_valid"}, 128'(out_valid_o), 128'(0));
        chk({tag, "_busy"}, 128'(busy_o), 128'(0));
        chk({tag, "_blk_cnt"}, 128'(blk_cnt_o), 128'(0));
        chk({tag, "_crypt_data"}, crypt_data_o, 128'(0));
        chk({tag, "_out_data"}, out_data_o, 128'(0));
        chk({tag, "_crypt_op"}, 128'(crypt_op_o), 128'(2'b01));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit ok;
        logic [127:0] d;
        bit dec, ecb, do_iv, do_clr;
        int r;
        repeat (3) @(negedge clk_i);
        #1 check_reset_vals("por");
        @(negedge clk_i);
        rst_ni = 1'b1;

        // zero-wait core: chaining, round trip, counter wrap 1,2,3,0
        set_waits(0, 0, 0, 0, 0, 0);
        lat_en = 1;
        load_ctrl(1, 128'h01, 0);
        send_block(128'h03, 0, 0, 0, '0, 0);
        send_block(128'h06, 0, 0, 0, '0, 0);
        load_ctrl(1, 128'hAA, 1);
        send_block(128'h05, 0, 0, 0, '0, 0);
        load_ctrl(1, 128'h01, 0);
        send_block(128'h02, 1, 0, 0, '0, 0);
        send_block(128'h04, 1, 0, 0, '0, 0);
        send_block(128'h77, 0, 0, 1, 128'h0F, 0);
        lat_en = 0;

        // back-pressure: ack held off 5 cycles, output stalled 4 cycles
        set_waits(5, 5, 0, 0, 4, 4);
        send_block(128'h1234, 0, 0, 0, '0, 0);

        // IV writes while the block is in WAIT and OUT are ignored
        set_waits(0, 0, 0, 0, 4, 4);
        load_ctrl(1, 128'h10, 0);
        send_block(128'h11, 0, 0, 0, '0, 0);
        @(negedge clk_i);
        iv_we_i = 1'b1; iv_i = 128'hFF;
        repeat (3) @(negedge clk_i);
        iv_we_i = 1'b0;
        send_block(128'h01, 0, 0, 0, '0, 0);

        // reset pulse while waiting for the core result
        set_waits(0, 0, 5, 5, 0, 0);
        send_block(128'hBEEF, 0, 0, 0, '0, 0);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1 check_reset_vals("mid_rst");
        exp_crypt_q.delete(); exp_op_q.delete(); exp_out_q.delete();
        m_chain = '0; exp_cnt = '0; lat_arm = 0; cnt_chk = 0;
        ack_armed = 0; res_pend = 0; rdy_armed = 0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        set_waits(0, 0, 0, 0, 0, 0);
        send_block(128'h5A, 0, 0, 0, '0, 0);

        // randomized traffic with random core latency and back-pressure
        for (int i = 0; i < 40; i++) begin
            set_waits(0, $urandom_range(3, 0), 0, $urandom_range(3, 0), 0, $urandom_range(3, 0));
            d = {$urandom, $urandom, $urandom, $urandom};
            dec = 1'($urandom_range(1, 0));
`ifdef AES_CBC_CHAIN_CTRL_ECB_EN
            ecb = ($urandom_range(3, 0) == 0);
`else
            ecb = 1'b0;
`endif
            r = $urandom_range(9, 0);
            do_clr = (r == 0) || (r == 2);
            do_iv = (r == 1) || (r == 2);
            send_block(d, dec, ecb, do_iv, {$urandom, $urandom, $urandom, $urandom}, do_clr);
        end

        // drain
        wait_idle("drain", ok);
        repeat (3) @(negedge clk_i);
        chk("drain_crypt_q", 128'(exp_crypt_q.size()), 128'(0));
        chk("drain_out_q", 128'(exp_out_q.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
